char_line_renderer: RTL

Renders a horizontal line of NUM_CHARS glyphs from the 16x16 character ROM at a programmable screen position, with integer pixel scaling and programmable foreground/background colours. Holds its own character buffer, written by a host port. Drives the ROM address, consumes ROM data, and outputs RGB pixels aligned to a fixed pipeline latency. Sits between the VGA sync counters and the VGA/HDMI output stage.

---
 rtl/char_line_pkg.sv | 28 ++
 rtl/char_line_renderer_delay.sv | 39 +++
 rtl/char_line_renderer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/char_line_pkg.sv
// -----------------------------------------------------------------------------
// char_line_pkg
// Shared constants for the character line renderer: glyph geometry, char ROM
// address layout, ASCII code width and the blank (space) code, plus a helper
// that gives the width of a packed {R,G,B} bundle.
// -----------------------------------------------------------------------------
package char_line_pkg;

  localparam int GLYPH_W    = 16;
  localparam int GLYPH_H    = 16;
  localparam int ROM_ADDR_W = 11;
  localparam int ASCII_W    = 7;
  localparam int POS_W      = 10;

  // Geometry compares run at this width so that x_pos + box width can never
  // overflow, even for 64 characters at 4x scale (1023 + 4096 < 2**14).
  // Boxes running past the counter range therefore clip rather than wrap.
  localparam int CMP_W      = 14;

  typedef logic [ASCII_W-1:0] ascii_t;

  localparam ascii_t ASCII_SPACE = 7'h20;

  function automatic int rgb_width(input int color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/char_line_renderer_delay.sv
// -----------------------------------------------------------------------------
// char_pipe_delay
// Plain register chain of DEPTH stages, WIDTH bits wide. Used to carry the
// per-pixel side information alongside the char ROM read latency.
//
// Ports
//   clk_i  clock
//   rst_i  asynchronous active-high reset, clears every stage
//   d_i    data in
//   q_o    data out, DEPTH cycles later
// -----------------------------------------------------------------------------
module char_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/char_line_renderer.sv
// -----------------------------------------------------------------------------
// char_line_renderer
// Renders one horizontal line of NUM_CHARS glyphs from a 16x16 char ROM at a
// programmable screen position, magnified by 2**SCALE_LOG2, in programmable
// foreground/background colours. Owns the character buffer (host written).
// Pixel latency h_cnt/v_cnt -> RGB/box_time is 2 + ROM_LAT cycles.
//
// Build option: define CHAR_LINE_CURSOR_EN to add a blinking cursor. It adds
// the cursor_idx input and a 6-bit frame counter; while counter bit 5 is set
// the selected cell renders with fg/bg swapped (32 frames on, 32 off).
//
// Ports
//   pix_clk              pixel clock
//   rst                  asynchronous active-high reset
//   h_cnt, v_cnt         pixel / line counters from the VGA sync block
//   x_pos, y_pos         top-left corner of the text box
//   wr_en/wr_idx/wr_char character buffer write port
//   fg_color, bg_color   {R,G,B} for glyph bit 1 / 0 inside the box
//   cursor_idx           cursor cell (CHAR_LINE_CURSOR_EN only)
//   rom_addr, rom_data   char ROM interface, {ascii, glyph_row}; bit 15 = left
//   box_time             output pixel lies inside the text box
//   red/green/blue_out   pixel colour, 0 outside the box
// -----------------------------------------------------------------------------
module char_line_renderer
  import char_line_pkg::*;
#(
  parameter int NUM_CHARS  = 16,
  parameter int SCALE_LOG2 = 0,
  parameter int ROM_LAT    = 1,
  parameter int COLOR_W    = 8
) (
  input  logic                           pix_clk,
  input  logic                           rst,
  input  logic [POS_W-1:0]               h_cnt,
  input  logic [POS_W-1:0]               v_cnt,
  input  logic [POS_W-1:0]               x_pos,
  input  logic [POS_W-1:0]               y_pos,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_CHARS)-1:0]   wr_idx,
  input  logic [ASCII_W-1:0]             wr_char,
  input  logic [rgb_width(COLOR_W)-1:0]  fg_color,
  input  logic [rgb_width(COLOR_W)-1:0]  bg_color,
`ifdef CHAR_LINE_CURSOR_EN
  input  logic [$clog2(NUM_CHARS)-1:0]   cursor_idx,
`endif
  output logic [ROM_ADDR_W-1:0]          rom_addr,
  input  logic [GLYPH_W-1:0]             rom_data,
  output logic                           box_time,
  output logic [COLOR_W-1:0]             red_out,
  output logic [COLOR_W-1:0]             green_out,
  output logic [COLOR_W-1:0]             blue_out
);

  localparam int IDX_W   = $clog2(NUM_CHARS);
  localparam int RGB_W   = rgb_width(COLOR_W);
  localparam int BOX_W   = (NUM_CHARS * GLYPH_W) << SCALE_LOG2;
  localparam int BOX_H   = GLYPH_H << SCALE_LOG2;
  localparam int ALIGN_W = 6;  // {in_box, col[3:0], cursor}

  // ---------------------------------------------------------------------------
  // Character buffer
  // ---------------------------------------------------------------------------
  ascii_t buf_q [NUM_CHARS];

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        buf_q[i] <= ASCII_SPACE;
      end
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_char;
    end
  end

  // ---------------------------------------------------------------------------
  // Box geometry and cell decode
  // ---------------------------------------------------------------------------
  logic [CMP_W-1:0] h_w, v_w, x_w, y_w;
  logic             in_box;

  assign h_w = CMP_W'(h_cnt);
  assign v_w = CMP_W'(v_cnt);
  assign x_w = CMP_W'(x_pos);
  assign y_w = CMP_W'(y_pos);

  assign in_box = (h_w >= x_w) && (h_w < x_w + CMP_W'(BOX_W)) &&
                  (v_w >= y_w) && (v_w < y_w + CMP_W'(BOX_H));

  // rel_x/rel_y are only meaningful inside the box, which is the only place
  // the decoded fields get used.
  logic [POS_W-1:0] rel_x, rel_y;
  logic [POS_W-1:0] col_full, idx_full, row_full;
  logic [3:0]       col, row;
  logic [IDX_W-1:0] idx;

  assign rel_x    = h_cnt - x_pos;
  assign rel_y    = v_cnt - y_pos;
  assign col_full = rel_x >> SCALE_LOG2;
  assign idx_full = rel_x >> (4 + SCALE_LOG2);
  assign row_full = rel_y >> SCALE_LOG2;
  assign col      = col_full[3:0];
  assign row      = row_full[3:0];
  assign idx      = idx_full[IDX_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{col_full, idx_full, row_full};

  // ---------------------------------------------------------------------------
  // Cursor
  // ---------------------------------------------------------------------------
  logic cur_hit;

`ifdef CHAR_LINE_CURSOR_EN
  logic [5:0] frame_q;

  // Counts cycles at the origin pixel, i.e. once per frame.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (h_cnt == '0 && v_cnt == '0) begin
      frame_q <= frame_q + 6'd1;
    end
  end

  assign cur_hit = frame_q[5] && (idx == cursor_idx);
`else
  assign cur_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: ROM lookup
  // ---------------------------------------------------------------------------
  logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic                  in_box_q;
  logic [3:0]            col_q;
  logic                  cur_q;

  // Outside the box the address is held so the ROM bus stays quiet.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (in_box) begin
      rom_addr_d = {buf_q[idx], row};
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      in_box_q   <= 1'b0;
      col_q      <= '0;
      cur_q      <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      in_box_q   <= in_box;
      col_q      <= col;
      cur_q      <= cur_hit;
    end
  end

  assign rom_addr = rom_addr_q;

  // ---------------------------------------------------------------------------
  // Stages 2..1+ROM_LAT: side info travels with the ROM read
  // ---------------------------------------------------------------------------
  logic [ALIGN_W-1:0] align_d, align_q;
  logic               in_box_a;
  logic [3:0]         col_a;
  logic               cur_a;

  assign align_d = {in_box_q, col_q, cur_q};

  char_pipe_delay #(
    .WIDTH (ALIGN_W),
    .DEPTH (ROM_LAT)
  ) u_align (
    .clk_i (pix_clk),
    .rst_i (rst),
    .d_i   (align_d),
    .q_o   (align_q)
  );

  assign in_box_a = align_q[5];
  assign col_a    = align_q[4:1];
  assign cur_a    = align_q[0];

  // ---------------------------------------------------------------------------
  // Final stage: pixel colour
  // ---------------------------------------------------------------------------
  logic             glyph_bit;
  logic [RGB_W-1:0] rgb_d, rgb_q;
  logic             box_q;

  // Bit 15 is the leftmost pixel, so column c selects bit 15-c == ~c.
  // The cursor swaps fg/bg, which is the same as inverting the glyph bit.
  always_comb begin
    glyph_bit = rom_data[~col_a] ^ cur_a;
    rgb_d     = '0;
    if (in_box_a) begin
      rgb_d = glyph_bit ? fg_color : bg_color;
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      box_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      box_q <= in_box_a;
    end
  end

  assign box_time  = box_q;
  assign red_out   = rgb_q[RGB_W-1 -: COLOR_W];
  assign green_out = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue_out  = rgb_q[COLOR_W-1:0];

endmodule
